// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and GF(2^8) helpers.
// Used by the round-key server and by the InvMixColumns transform.
package aes_pkg;

  localparam int AES256_ROUNDS = 14;
  localparam int AES192_ROUNDS = 12;
  localparam int AES128_ROUNDS = 10;

  // Round key, byte 0 in bits [0:7] (MSB-first).
  typedef logic [0:127] round_key_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant, enough for the InvMixColumns
  // coefficients 09, 0b, 0d and 0e.
  function automatic logic [7:0] gf_mul_by(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = gf_mul2(b);
    x4 = gf_mul2(x2);
    x8 = gf_mul2(x4);
    return (c[0] ? b  : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^
           (c[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over a 128-bit state, four 32-bit columns.
// Used to produce equivalent-inverse-cipher round keys.
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  round_key_t data_i,
  output round_key_t data_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;

    assign s0 = data_i[32*c      +: 8];
    assign s1 = data_i[32*c + 8  +: 8];
    assign s2 = data_i[32*c + 16 +: 8];
    assign s3 = data_i[32*c + 24 +: 8];

    assign data_o[32*c      +: 8] = gf_mul_by(s0, 4'he) ^ gf_mul_by(s1, 4'hb) ^
                                    gf_mul_by(s2, 4'hd) ^ gf_mul_by(s3, 4'h9);
    assign data_o[32*c + 8  +: 8] = gf_mul_by(s0, 4'h9) ^ gf_mul_by(s1, 4'he) ^
                                    gf_mul_by(s2, 4'hb) ^ gf_mul_by(s3, 4'hd);
    assign data_o[32*c + 16 +: 8] = gf_mul_by(s0, 4'hd) ^ gf_mul_by(s1, 4'h9) ^
                                    gf_mul_by(s2, 4'he) ^ gf_mul_by(s3, 4'hb);
    assign data_o[32*c + 24 +: 8] = gf_mul_by(s0, 4'hb) ^ gf_mul_by(s1, 4'hd) ^
                                    gf_mul_by(s2, 4'h9) ^ gf_mul_by(s3, 4'he);
  end

endmodule

// File: rtl/aes_round_key_server.sv
// Round-key server: takes a full expanded key bundle in one handshake and
// streams one round key per beat, forward (encrypt) or reverse (decrypt).
// Optional macro AES_EQ_INV_KEY_EN: in decrypt streams, middle round keys
// pass through InvMixColumns for the equivalent inverse cipher.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   IDLE   | ready for a bundle; no key on the output
//   STREAM | presenting stored key[idx]; advances on each yumi_i
module aes_round_key_server
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_ROUNDS,
  parameter int IDX_W      = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [0:128*(NUM_ROUNDS+1)-1] round_keys_i,
  input  logic                          decrypt_i,
  input  logic                          v_i,
  output logic                          ready_o,
  output round_key_t                    round_key_o,
  output logic [IDX_W-1:0]              round_idx_o,
  output logic                          last_o,
  output logic                          v_o,
  input  logic                          yumi_i
);

  localparam int               BUNDLE_W = 128 * (NUM_ROUNDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  state_t              state_q;
  state_t              state_d;
  logic [0:BUNDLE_W-1] bundle_q;
  logic                dec_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic                load;
  logic                at_last;
  round_key_t          key_arr [NUM_ROUNDS+1];
  round_key_t          raw_key;
  round_key_t          out_key;

  // State register; reset aborts any stream in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bundle, direction and index storage.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bundle_q <= '0;
      dec_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      if (load) begin
        bundle_q <= round_keys_i;
        dec_q    <= decrypt_i;
      end
      idx_q <= idx_d;
    end
  end

  // Final key is idx 0 going backwards, NUM_ROUNDS going forwards. Checking
  // this before stepping keeps the index from ever wrapping.
  assign at_last = dec_q ? (idx_q == '0) : (idx_q == LAST_IDX);

  // Next state, index stepping and handshake outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    ready_o = 1'b0;
    v_o     = 1'b0;
    last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          load    = 1'b1;
          idx_d   = decrypt_i ? LAST_IDX : '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        v_o    = 1'b1;
        last_o = at_last;
        if (yumi_i) begin
          if (at_last) begin
            state_d = IDLE;
          end else if (dec_q) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k <= NUM_ROUNDS; k++) begin : g_split
    assign key_arr[k] = bundle_q[128*k +: 128];
  end

  // Select the stored key at the current index.
  always_comb begin
    raw_key = '0;
    for (int k = 0; k <= NUM_ROUNDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        raw_key = key_arr[k];
      end
    end
  end

`ifdef AES_EQ_INV_KEY_EN
  round_key_t imc_key;
  logic       use_imc;

  aes_inv_mix_columns u_inv_mix (
    .data_i (raw_key),
    .data_o (imc_key)
  );

  // First and last schedule keys are AddRoundKey-only in the equivalent
  // inverse cipher, so they stay raw.
  assign use_imc = dec_q && (idx_q != '0) && (idx_q != LAST_IDX);
  assign out_key = use_imc ? imc_key : raw_key;
`else
  assign out_key = raw_key;
`endif

  assign round_key_o = (state_q == STREAM) ? out_key : '0;
  assign round_idx_o = (state_q == STREAM) ? idx_q   : '0;

endmodule

// File: tb/tb_aes_round_key_server.sv
// Bench for aes_round_key_server (AES-256 schedule). Builds bundles with a
// software key expansion, keeps a queue of expected beats and compares the
// DUT against it every cycle, plus literal checks on known schedule keys.
module tb_aes_round_key_server;
  import aes_pkg::*;

  localparam int NR = 14;
  localparam int BW = 128 * (NR + 1);

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [0:BW-1]   round_keys_i;
  logic            decrypt_i;
  logic            v_i;
  logic            yumi_i;
  logic            ready_o;
  round_key_t      round_key_o;
  logic [3:0]      round_idx_o;
  logic            last_o;
  logic            v_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [7:0]    sb [256];
  logic [0:BW-1] bundle_a;
  logic [0:BW-1] bundle_b;
  logic [127:0]  obs_key  [16];
  int            obs_idx  [16];
  bit            obs_last [16];
  int            nbeats;
  int            vcount;

  typedef struct {
    logic [127:0] key;
    int           idx;
    bit           last;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk_i = ~clk_i;

  aes_round_key_server #(.NUM_ROUNDS(NR), .IDX_W(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .round_keys_i (round_keys_i),
    .decrypt_i    (decrypt_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .round_key_o  (round_key_o),
    .round_idx_o  (round_idx_o),
    .last_o       (last_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [0:BW-1] make_bundle(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:BW-1] b;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k <= NR; k++)
      b[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return b;
  endfunction

  function automatic logic [127:0] sw_imc(input logic [127:0] x);
    logic [7:0]   coef [4];
    logic [7:0]   s [4];
    logic [7:0]   acc;
    logic [127:0] y;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) s[j] = x[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], s[j]);
        y[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return y;
  endfunction

  // Expected-beat model: a bundle becomes a list of keys in stream order;
  // each accepted beat removes one entry; reset empties the list.
  initial begin : model
    beat_t e;
    forever begin
      @(posedge clk_i or negedge reset_i);
      if (reset_i !== 1'b1) begin
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        if (yumi_i === 1'b1) void'(exp_q.pop_front());
      end else if (v_i === 1'b1) begin
        for (int k = 0; k <= NR; k++) begin
          e.idx  = decrypt_i ? NR - k : k;
          e.key  = round_keys_i[128*e.idx +: 128];
`ifdef AES_EQ_INV_KEY_EN
          if (decrypt_i && e.idx > 0 && e.idx < NR) e.key = sw_imc(e.key);
`endif
          e.last = (k == NR);
          exp_q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk_i);
      if (cmp_en) begin
        if (exp_q.size() == 0) begin
          check("cmp_ready", ready_o, 1);
          check("cmp_v", v_o, 0);
        end else begin
          check("cmp_ready", ready_o, 0);
          check("cmp_v", v_o, 1);
          check("cmp_key", round_key_o, exp_q[0].key);
          check("cmp_idx", 128'(round_idx_o), 128'(exp_q[0].idx));
          check("cmp_last", last_o, exp_q[0].last);
        end
      end
    end
  end

  task automatic present(input logic [0:BW-1] b, input logic dec, input bit keep,
                         input logic [0:BW-1] nb);
    int guard;
    guard = 0;
    @(negedge clk_i);
    round_keys_i = b;
    decrypt_i    = dec;
    v_i          = 1'b1;
    while (ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    if (keep) round_keys_i = nb;
    else v_i = 1'b0;
  endtask

  // mode 0: yumi every beat; mode 1: yumi pattern 1,0,0,1 repeating.
  // stop_at >= 0 returns while beat number stop_at is being presented.
  task automatic consume(input int mode, input int stop_at);
    int cyc;
    int stall;
    bit done;
    bit y;
    cyc = 0; stall = 0; done = 1'b0; nbeats = 0; vcount = 0;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (v_o === 1'b1) begin
        if (nbeats == stop_at) begin
          yumi_i = 1'b0;
          done   = 1'b1;
        end else begin
          vcount++;
          y = (mode == 0) ? 1'b1 : ((stall % 4 == 0) || (stall % 4 == 3));
          stall++;
          yumi_i = y;
          if (y) begin
            obs_key[nbeats]  = round_key_o;
            obs_idx[nbeats]  = int'(round_idx_o);
            obs_last[nbeats] = last_o;
            nbeats++;
            if (last_o) done = 1'b1;
          end
        end
      end else begin
        yumi_i = 1'b0;
      end
    end
    if (!done) check("consume_timeout", 0, 1);
    else if (stop_at < 0) begin
      @(posedge clk_i);
      #1 yumi_i = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    reset_i      = 1'b0;
    v_i          = 1'b0;
    yumi_i       = 1'b0;
    decrypt_i    = 1'b0;
    round_keys_i = '0;

    init_sbox();
    bundle_a = make_bundle(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    bundle_b = make_bundle({32{8'h64}});

    // Pin the bench's own AES arithmetic.
    check("model_sbox53", sb[8'h53], 8'hed);
    check("model_rk0",  bundle_a[0     +: 128], 128'h000102030405060708090a0b0c0d0e0f);
    check("model_rk1",  bundle_a[128   +: 128], 128'h101112131415161718191a1b1c1d1e1f);
    check("model_rk2",  bundle_a[256   +: 128], 128'ha573c29fa176c498a97fce93a572c09c);
    check("model_rk14", bundle_a[128*14 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("model_imc",  sw_imc({4{32'h8e4da1bc}}), {4{32'hdb135345}});

    // Reset state.
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_v", v_o, 0);
    check("rst_last", last_o, 0);
    check("rst_idx", round_idx_o, 0);
    check("rst_key", round_key_o, 0);
    #1 reset_i = 1'b1;
    cmp_en = 1'b1;

    // yumi_i while idle must not disturb anything.
    yumi_i = 1'b1;
    repeat (3) @(negedge clk_i);
    yumi_i = 1'b0;

    // Forward stream.
    present(bundle_a, 1'b0, 1'b0, '0);
    consume(0, -1);
    check("fwd_vcount", vcount, 15);
    check("fwd_beats", nbeats, 15);
    check("fwd_beat0", obs_key[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("fwd_beat1", obs_key[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("fwd_beat2", obs_key[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check("fwd_beat14", obs_key[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("fwd_last14", obs_last[14], 1);
    check("fwd_last13", obs_last[13], 0);
    check("fwd_idx14", obs_idx[14], 14);

    // Reverse stream.
    present(bundle_a, 1'b1, 1'b0, '0);
    consume(0, -1);
    check("dec_beats", nbeats, 15);
    check("dec_first_idx", obs_idx[0], 14);
    check("dec_first_key", obs_key[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("dec_last_idx", obs_idx[14], 0);
    check("dec_last_key", obs_key[14], 128'h000102030405060708090a0b0c0d0e0f);
    check("dec_last_flag", obs_last[14], 1);
`ifdef AES_EQ_INV_KEY_EN
    check("dec_imc_idx13", obs_key[1], sw_imc(bundle_a[128*13 +: 128]));
    check("dec_imc_idx1", obs_key[13], sw_imc(bundle_a[128 +: 128]));
`else
    check("dec_raw_idx13", obs_key[1], bundle_a[128*13 +: 128]);
    check("dec_raw_idx1", obs_key[13], 128'h101112131415161718191a1b1c1d1e1f);
`endif

    // Backpressure: every index exactly once, in order.
    present(bundle_a, 1'b0, 1'b0, '0);
    consume(1, -1);
    check("bp_beats", nbeats, 15);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("bp_idx%0d", k), obs_idx[k], k);
      check($sformatf("bp_key%0d", k), obs_key[k], bundle_a[128*k +: 128]);
    end

    // Back-to-back: second bundle waits with v_i high through the first stream.
    present(bundle_a, 1'b0, 1'b1, bundle_b);
    consume(0, -1);
    check("b2b_first_beats", nbeats, 15);
    @(negedge clk_i);
    check("b2b_bubble_ready", ready_o, 1);
    check("b2b_bubble_v", v_o, 0);
    @(posedge clk_i);
    #1 v_i = 1'b0;
    @(negedge clk_i);
    check("b2b_second_v", v_o, 1);
    check("b2b_second_key", round_key_o, {16{8'h64}});
    check("b2b_second_idx", round_idx_o, 0);
    consume(0, -1);
    check("b2b_second_beats", nbeats, 15);

    // Reset during beat 5 of a forward stream.
    present(bundle_a, 1'b0, 1'b0, '0);
    consume(0, 5);
    check("abort_idx", round_idx_o, 5);
    #2 reset_i = 1'b0;
    #1;
    check("abort_rst_v", v_o, 0);
    check("abort_rst_ready", ready_o, 1);
    check("abort_rst_idx", round_idx_o, 0);
    check("abort_rst_key", round_key_o, 0);
    check("abort_rst_last", last_o, 0);
    repeat (2) @(negedge clk_i);
    #2 reset_i = 1'b1;
    present(bundle_b, 1'b0, 1'b0, '0);
    consume(0, -1);
    check("abort_new_beats", nbeats, 15);
    check("abort_new_idx0", obs_idx[0], 0);
    check("abort_new_key0", obs_key[0], {16{8'h64}});

    repeat (2) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
